// File: rtl/sensor_sampler.sv
// Polls four height sensors over a shared req/valid bus and publishes all readings atomically.
// Optional continuous scanning is enabled by defining SENSOR_SAMPLER_AUTOSCAN_EN.
module sensor_sampler #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [1:0] sel,
  output logic       req,
  input  logic [7:0] bus_data,
  input  logic       bus_valid,
  output logic [7:0] sensor1,
  output logic [7:0] sensor2,
  output logic [7:0] sensor3,
  output logic [7:0] sensor4,
  output logic [3:0] fault,
  output logic       snap_valid,
  output logic       busy,
  output logic [1:0] state_dbg
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [7:0]    shadow [4];
  logic [3:0]    shadow_fault;
  logic          capture;
  logic          publish;
  logic [7:0]    cap_data;
  logic          cap_fault;

  // A REQ phase ends on valid data or on its last allowed cycle; valid wins a tie.
  assign capture   = (state == ST_REQ) && (bus_valid || (cnt == CNT_LAST));
  assign publish   = capture && (sel == 2'd3);
  assign cap_data  = bus_valid ? bus_data : 8'd0;
  assign cap_fault = ~bus_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
`ifdef SENSOR_SAMPLER_AUTOSCAN_EN
        state_next = ST_REQ;
`else
        if (start) state_next = ST_REQ;
`endif
      end
      ST_REQ: begin
        if (capture) begin
`ifdef SENSOR_SAMPLER_AUTOSCAN_EN
          state_next = ST_GAP;
`else
          state_next = publish ? ST_IDLE : ST_GAP;
`endif
        end
      end
      ST_GAP:  state_next = ST_REQ;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req       = (state == ST_REQ);
    busy      = (state != ST_IDLE);
    state_dbg = state;
  end

  // In autoscan the GAP after sensor 3 wraps sel back to 0, doubling as the restart cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel          <= 2'd0;
      cnt          <= '0;
      shadow_fault <= 4'd0;
      sensor1      <= 8'd0;
      sensor2      <= 8'd0;
      sensor3      <= 8'd0;
      sensor4      <= 8'd0;
      fault        <= 4'd0;
      snap_valid   <= 1'b0;
      for (int i = 0; i < 4; i++) shadow[i] <= 8'd0;
    end else begin
      snap_valid <= publish;
      case (state)
        ST_IDLE: begin
          sel <= 2'd0;
          cnt <= '0;
        end
        ST_REQ: begin
          if (capture) begin
            shadow[sel]       <= cap_data;
            shadow_fault[sel] <= cap_fault;
            cnt               <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_GAP: begin
          sel <= sel + 2'd1;
          cnt <= '0;
        end
        default: ;
      endcase
      if (publish) begin
        sensor1 <= shadow[0];
        sensor2 <= shadow[1];
        sensor3 <= shadow[2];
        sensor4 <= cap_data;
        fault   <= {cap_fault, shadow_fault[2:0]};
      end
    end
  end

endmodule
